// File: rtl/hilo_ctrl.sv
// HI/LO write sequencer for EX: MTHI/MTLO, a registered multiplier,
// and a 32-iteration restoring divider, with pipeline stall and flush.
module hilo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic [31:0] hi_cur_i,
    input  logic [31:0] lo_cur_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int DATA_BUS = 32;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_n;

    logic [DATA_BUS-1:0] a_q, b_q, dvs_q, quo_q, rem_q;
    logic [DATA_BUS-1:0] hi_q, lo_q;
    logic                sgn_q, qneg_q, rneg_q, we_q;
    logic [4:0]          cnt;

    logic                op_ok, is_arith, is_div, is_sgn, accept;
    logic [DATA_BUS-1:0] hi_byp, lo_byp, a_mag, b_mag;
    logic [2*DATA_BUS-1:0] prod;
    logic [DATA_BUS:0]   shifted, diff;
    logic                ge;
    logic [DATA_BUS-1:0] rem_n, quo_n, q_fix, r_fix;

    always_comb begin
        op_ok    = (op_i != 3'd0) && (op_i != 3'd7);
        is_arith = (op_i >= OP_MULT) && (op_i <= OP_DIVU);
        is_div   = (op_i == OP_DIV) || (op_i == OP_DIVU);
        is_sgn   = (op_i == OP_MULT) || (op_i == OP_DIV);
        accept   = valid_i && (state == IDLE) && !flush_i && op_ok;
        stall_o  = !rst && !flush_i &&
                   ((accept && is_arith) || (state == MUL) || (state == DIV));
        hilo_we_o = we_q && !flush_i;
        hi_o     = hi_q;
        lo_o     = lo_q;
    end

    // Bypass so MTHI followed by MTLO sees the not-yet-written half.
    assign hi_byp = hilo_we_o ? hi_q : hi_cur_i;
    assign lo_byp = hilo_we_o ? lo_q : lo_cur_i;

    assign a_mag = (is_sgn && src_a_i[31]) ? -src_a_i : src_a_i;
    assign b_mag = (is_sgn && src_b_i[31]) ? -src_b_i : src_b_i;

    assign prod = {{DATA_BUS{sgn_q & a_q[31]}}, a_q} *
                  {{DATA_BUS{sgn_q & b_q[31]}}, b_q};

    always_comb begin
        shifted = {rem_q, quo_q[DATA_BUS-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = !diff[DATA_BUS];
        rem_n   = ge ? diff[DATA_BUS-1:0] : shifted[DATA_BUS-1:0];
        quo_n   = {quo_q[DATA_BUS-2:0], ge};
        q_fix   = qneg_q ? -quo_n : quo_n;
        r_fix   = rneg_q ? -rem_n : rem_n;
    end

    always_comb begin
        state_n = state;
        if (flush_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (accept && is_arith)
                          state_n = is_div ? DIV : MUL;
                MUL:  state_n = DONE;
                DIV:  if (cnt == 5'd31) state_n = DONE;
                DONE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            sgn_q  <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            we_q   <= 1'b0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (flush_i) begin
            we_q <= 1'b0;
            cnt  <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (op_i == OP_MTHI) begin
                        we_q <= 1'b1;
                        hi_q <= src_a_i;
                        lo_q <= lo_byp;
                    end else if (op_i == OP_MTLO) begin
                        we_q <= 1'b1;
                        hi_q <= hi_byp;
                        lo_q <= src_a_i;
                    end else begin
                        a_q    <= src_a_i;
                        b_q    <= src_b_i;
                        sgn_q  <= is_sgn;
                        dvs_q  <= b_mag;
                        quo_q  <= a_mag;
                        rem_q  <= '0;
                        qneg_q <= is_sgn && (src_a_i[31] ^ src_b_i[31]);
                        rneg_q <= is_sgn && src_a_i[31];
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    we_q <= 1'b1;
                    hi_q <= prod[2*DATA_BUS-1:DATA_BUS];
                    lo_q <= prod[DATA_BUS-1:0];
                end
                DIV: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        we_q <= 1'b1;
                        if (dvs_q == '0) begin
                            hi_q <= a_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: MTHI/MTLO bypass, mul/div results,
// latency, flush and asynchronous reset behaviour.
module tb_hilo_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] src_a_i, src_b_i, hi_cur_i, lo_cur_i;
    logic        flush_i;
    logic        stall_o, hilo_we_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    hilo_ctrl dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i),
        .hi_cur_i(hi_cur_i), .lo_cur_i(lo_cur_i),
        .flush_i(flush_i), .stall_o(stall_o), .hilo_we_o(hilo_we_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue op in the current cycle T and follow it to its write cycle.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int lat);
        int st;
        int we_n;
        valid_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        #1;
        chk({tag, "_we_t0"}, {31'd0, hilo_we_o}, 32'd0);
        st = stall_o ? 1 : 0;
        we_n = 0;
        for (int k = 1; k < lat; k++) begin
            step();
            valid_i = 1'b0;
            #1;
            st += stall_o ? 1 : 0;
            we_n += hilo_we_o ? 1 : 0;
        end
        step();
        valid_i = 1'b0;
        #1;
        chk({tag, "_stall_cyc"}, st, lat);
        chk({tag, "_we_early"}, we_n, 0);
        chk({tag, "_we"}, {31'd0, hilo_we_o}, 32'd1);
        chk({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
        chk({tag, "_hi"}, hi_o, eh);
        chk({tag, "_lo"}, lo_o, el);
    endtask

    initial begin
        int we_n;
        rst = 1'b1; valid_i = 1'b1; op_i = 3'd1;
        src_a_i = '0; src_b_i = '0; hi_cur_i = '0; lo_cur_i = '0;
        flush_i = 1'b0;
        #12;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_we", {31'd0, hilo_we_o}, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        valid_i = 1'b0; op_i = 3'd0;
        step();
        rst = 1'b0;

        // MTHI
        step();
        valid_i = 1'b1; op_i = 3'd5; src_a_i = 32'h12345678;
        hi_cur_i = 32'h0; lo_cur_i = 32'hAAAA0000;
        #1;
        chk("mthi_stall", {31'd0, stall_o}, 32'd0);
        step();
        valid_i = 1'b0;
        #1;
        chk("mthi_we", {31'd0, hilo_we_o}, 32'd1);
        chk("mthi_hi", hi_o, 32'h12345678);
        chk("mthi_lo", lo_o, 32'hAAAA0000);
        step();
        chk("mthi_pulse", {31'd0, hilo_we_o}, 32'd0);

        // MTHI then MTLO back to back with stale HI/LO inputs
        hi_cur_i = 32'h0; lo_cur_i = 32'h0;
        valid_i = 1'b1; op_i = 3'd5; src_a_i = 32'h11111111;
        step();
        op_i = 3'd6; src_a_i = 32'h22222222;
        #1;
        chk("b2b_we1", {31'd0, hilo_we_o}, 32'd1);
        chk("b2b_stall", {31'd0, stall_o}, 32'd0);
        step();
        valid_i = 1'b0;
        #1;
        chk("b2b_we2", {31'd0, hilo_we_o}, 32'd1);
        chk("b2b_hi", hi_o, 32'h11111111);
        chk("b2b_lo", lo_o, 32'h22222222);

        step();
        run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 2);
        step();
        run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 2);
        step();
        run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        step();
        run_op("divu", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        step();
        chk("hold_we", {31'd0, hilo_we_o}, 32'd0);
        chk("hold_lo", lo_o, 32'd14);
        run_op("div0", 3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33);
        step();
        run_op("sdiv0", 3'd3, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, 33);
        step();
        run_op("ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);

        // Flush mid-divide, then a MULT right after
        step();
        valid_i = 1'b1; op_i = 3'd3; src_a_i = 32'd50; src_b_i = 32'd3;
        #1;
        chk("fl_stall_t0", {31'd0, stall_o}, 32'd1);
        we_n = 0;
        for (int k = 1; k < 10; k++) begin
            step();
            valid_i = 1'b0;
            #1;
            we_n += hilo_we_o ? 1 : 0;
        end
        chk("fl_stall_t9", {31'd0, stall_o}, 32'd1);
        step();
        flush_i = 1'b1;
        valid_i = 1'b1; op_i = 3'd1;
        #1;
        chk("fl_stall", {31'd0, stall_o}, 32'd0);
        we_n += hilo_we_o ? 1 : 0;
        chk("fl_no_we", we_n, 0);
        step();
        flush_i = 1'b0;
        run_op("fl_mult", 3'd1, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 2);

        // Asynchronous reset in the middle of a divide
        step();
        valid_i = 1'b1; op_i = 3'd4; src_a_i = 32'd9; src_b_i = 32'd4;
        for (int k = 0; k < 5; k++) begin
            step();
            valid_i = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stall", {31'd0, stall_o}, 32'd0);
        chk("arst_hi", hi_o, 32'd0);
        chk("arst_lo", lo_o, 32'd0);
        step();
        rst = 1'b0;
        we_n = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            we_n += (hilo_we_o || stall_o) ? 1 : 0;
        end
        chk("arst_quiet", we_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1);
    end
endmodule
